// File: rtl/mul8_r4_seq.sv
// mul8_r4_seq: radix-4 sequential 8x8 unsigned multiplier that uses an external 2-to-4 decoder to select the digit
module mul8_r4_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [1:0]  digit,
    input  logic [3:0]  sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] y,
    output logic        err
);
    typedef enum logic {IDLE, STEP} state_t;
    state_t state, state_nx;
    logic [1:0] cnt;
    logic [7:0] ra, rb;
    logic [15:0] acc, acc_nx;
    logic [9:0] pp;
    logic bad;
    assign busy = state == STEP;
    assign digit = busy ? rb[1:0] : 2'd0;
    always_comb begin
        state_nx = state == IDLE ? (start ? STEP : IDLE) : (cnt == 2'd3 ? IDLE : STEP);
        bad = !$onehot(sel);
        pp = sel == 4'b0010 ? {2'd0, ra} :
             sel == 4'b0100 ? {1'b0, ra, 1'b0} :
             sel == 4'b1000 ? {2'd0, ra} + {1'b0, ra, 1'b0} : 10'd0;
        acc_nx = acc + ({6'd0, pp} << {cnt, 1'b0});
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
            ra <= 8'd0;
            rb <= 8'd0;
            acc <= 16'd0;
            y <= 16'd0;
            done <= 1'b0;
            err <= 1'b0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start) begin
                ra <= a;
                rb <= b;
                acc <= 16'd0;
                cnt <= 2'd0;
                err <= 1'b0;
            end
        end else begin
            acc <= acc_nx;
            rb <= rb >> 2;
            cnt <= cnt + 2'd1;
            done <= cnt == 2'd3;
            if (bad) err <= 1'b1;
            if (cnt == 2'd3) y <= acc_nx;
        end
    end
endmodule
